// File: rtl/soft_decoder_multi.sv
// Multi-read soft decoder controller: sequences each noisy read through external matrices and
// likelihood engines, then sums the per-position likelihoods with saturation across reads.
module soft_decoder_multi #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int n           = 10,
    parameter  int LLR_W       = 32,
    parameter  int ACC_W       = 40,
    parameter  int NUM_STRANDS = 4,
    parameter  int TIMEOUT     = 4095,
    localparam int LEN_W       = $clog2(DATA_WIDTH + 1),
    localparam int CNT_W       = $clog2(NUM_STRANDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_WIDTH-1:0] in_strand,
    input  logic [LEN_W-1:0]     in_len,
    input  logic                 in_last,
    output logic                 eng_mat_start,
    input  logic                 eng_mat_done,
    output logic                 eng_lik_start,
    input  logic                 eng_lik_done,
    output logic [DATA_WIDTH-1:0] eng_strand,
    output logic [LEN_W-1:0]     eng_len,
    input  logic [n*LLR_W-1:0]   eng_lik,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n*ACC_W-1:0]   out_llr,
    output logic [CNT_W-1:0]     out_count,
    output logic [2:0]           out_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] MAX_RD  = CNT_W'(NUM_STRANDS);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, MAT_START, MAT_WAIT, LIK_START, LIK_WAIT, ACC, OUT} state_t;

    state_t                state_q;
    logic                  in_ready_q, mat_start_q, lik_start_q, out_valid_q, last_q;
    logic [DATA_WIDTH-1:0] strand_q;
    logic [LEN_W-1:0]      len_q;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d, count_q;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [n*LLR_W-1:0]    lik_q;
    logic [n*ACC_W-1:0]    acc_q, acc_d;
    logic [2:0]            err_q;
    logic                  read_end;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [LLR_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W + 1 - LLR_W){b[LLR_W-1]}}, b};
        // Differing top two bits of the widened sum mean the true result left the ACC_W range.
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < n; k++)
            acc_d[k*ACC_W +: ACC_W] = sat_add(acc_q[k*ACC_W +: ACC_W], lik_q[k*LLR_W +: LLR_W]);
    end

    assign to_cnt_d = to_cnt_q + TO_W'(1);
    assign rd_cnt_d = rd_cnt_q + CNT_W'(1);
    assign read_end = last_q || (rd_cnt_q == MAX_RD);

    // NOTE: the accumulator bank is reset like any other state because a reset must abort the
    // codeword and present zeros; all state updates here are non-blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mat_start_q <= 1'b0;
            lik_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            strand_q    <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            count_q     <= '0;
            to_cnt_q    <= '0;
            lik_q       <= '0;
            acc_q       <= '0;
            err_q       <= '0;
        end else begin
            mat_start_q <= 1'b0;
            lik_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        strand_q <= in_strand;
                        len_q    <= in_len;
                        last_q   <= in_last;
                        rd_cnt_q <= rd_cnt_d;
                        if (in_len == '0 || in_len > MAX_LEN) begin
                            err_q[0] <= 1'b1;
                            if (in_last || rd_cnt_d == MAX_RD) begin
                                state_q     <= OUT;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= MAT_START;
                            in_ready_q  <= 1'b0;
                            mat_start_q <= 1'b1;
                        end
                    end
                end
                MAT_START: begin
                    to_cnt_q <= '0;
                    state_q  <= MAT_WAIT;
                end
                MAT_WAIT: begin
                    if (eng_mat_done) begin
                        state_q     <= LIK_START;
                        lik_start_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_cnt_d == TO_LIM) begin
                            err_q[1]    <= 1'b1;
                            state_q     <= read_end ? OUT : IDLE;
                            in_ready_q  <= !read_end;
                            out_valid_q <= read_end;
                        end
                    end
                end
                LIK_START: begin
                    to_cnt_q <= '0;
                    state_q  <= LIK_WAIT;
                end
                LIK_WAIT: begin
                    if (eng_lik_done) begin
                        lik_q   <= eng_lik;
                        state_q <= ACC;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_cnt_d == TO_LIM) begin
                            err_q[2]    <= 1'b1;
                            state_q     <= read_end ? OUT : IDLE;
                            in_ready_q  <= !read_end;
                            out_valid_q <= read_end;
                        end
                    end
                end
                ACC: begin
                    acc_q       <= acc_d;
                    count_q     <= count_q + CNT_W'(1);
                    state_q     <= read_end ? OUT : IDLE;
                    in_ready_q  <= !read_end;
                    out_valid_q <= read_end;
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        count_q     <= '0;
                        err_q       <= '0;
                        rd_cnt_q    <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign eng_mat_start = mat_start_q;
    assign eng_lik_start = lik_start_q;
    assign eng_strand    = strand_q;
    assign eng_len       = len_q;
    assign out_valid     = out_valid_q;
    assign out_llr       = acc_q;
    assign out_count     = count_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_soft_decoder_multi.sv
// Bench for soft_decoder_multi: engine models with programmable latency, a clamp-and-sum
// reference model of the combined likelihoods, directed corner cases and a random read stream.
module tb_soft_decoder_multi;

    localparam int DW = 32, NP = 4, LW = 8, AW = 8, NS = 4, TO = 20;
    localparam int LENW = $clog2(DW + 1), CNTW = $clog2(NS + 1);
    localparam int AMAX = (1 << (AW - 1)) - 1, AMIN = -(1 << (AW - 1));

    logic            clk, rst_n;
    logic            in_valid, in_ready, in_last;
    logic [DW-1:0]   in_strand, eng_strand;
    logic [LENW-1:0] in_len, eng_len;
    logic            eng_mat_start, eng_mat_done, eng_lik_start, eng_lik_done;
    logic [NP*LW-1:0] eng_lik;
    logic            out_valid, out_ready;
    logic [NP*AW-1:0] out_llr;
    logic [CNTW-1:0] out_count;
    logic [2:0]      out_err;

    soft_decoder_multi #(.DATA_WIDTH(DW), .n(NP), .LLR_W(LW), .ACC_W(AW),
                         .NUM_STRANDS(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_strand(in_strand),
        .in_len(in_len), .in_last(in_last),
        .eng_mat_start(eng_mat_start), .eng_mat_done(eng_mat_done),
        .eng_lik_start(eng_lik_start), .eng_lik_done(eng_lik_done),
        .eng_strand(eng_strand), .eng_len(eng_len), .eng_lik(eng_lik),
        .out_valid(out_valid), .out_ready(out_ready), .out_llr(out_llr),
        .out_count(out_count), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Engine stimulus for the read in flight (latency 0 means the engine never answers).
    int              cur_mat_lat, cur_lik_lat;
    int              cur_lik[NP];
    logic [DW-1:0]   exp_strand;
    logic [LENW-1:0] exp_len;
    int              mat_starts = 0, lik_starts = 0;
    int              mat_cd, lik_cd;

    initial begin
        eng_mat_done = 1'b0; eng_lik_done = 1'b0; eng_lik = '0;
        mat_cd = 0; lik_cd = 0;
        forever begin
            @(negedge clk);
            eng_mat_done = 1'b0;
            eng_lik_done = 1'b0;
            for (int k = 0; k < NP; k++) eng_lik[k*LW +: LW] = LW'($urandom);
            if (!rst_n) begin
                mat_cd = 0; lik_cd = 0;
            end else begin
                if (eng_mat_start) begin
                    mat_starts++;
                    check("eng_strand", eng_strand, exp_strand);
                    check("eng_len", eng_len, exp_len);
                    check("start_overlap", eng_lik_start, 0);
                    mat_cd = cur_mat_lat;
                end else if (mat_cd > 0) begin
                    mat_cd--;
                    if (mat_cd == 0) eng_mat_done = 1'b1;
                end
                if (eng_lik_start) begin
                    lik_starts++;
                    check("eng_strand_lik", eng_strand, exp_strand);
                    lik_cd = cur_lik_lat;
                end else if (lik_cd > 0) begin
                    lik_cd--;
                    if (lik_cd == 0) begin
                        eng_lik_done = 1'b1;
                        for (int k = 0; k < NP; k++) eng_lik[k*LW +: LW] = LW'(cur_lik[k]);
                    end
                end
            end
        end
    end

    // Reference model: per-read outcome decided from length and engine latencies.
    int m_rd, m_cnt, m_err;
    int m_acc[NP];

    function automatic int clamp(input int v);
        return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
    endfunction

    task automatic model_clear();
        m_rd = 0; m_cnt = 0; m_err = 0;
        for (int k = 0; k < NP; k++) m_acc[k] = 0;
    endtask

    task automatic model_read(input int l, input bit last, input int mlat, input int llat,
                              output bit out_now);
        m_rd++;
        if (l == 0 || l > DW) m_err |= 1;
        else if (mlat == 0 || mlat > TO) m_err |= 2;
        else if (llat == 0 || llat > TO) m_err |= 4;
        else begin
            for (int k = 0; k < NP; k++) m_acc[k] = clamp(m_acc[k] + cur_lik[k]);
            m_cnt++;
        end
        out_now = last || (m_rd == NS);
    endtask

    task automatic check_out();
        int ms;
        check("out_valid", out_valid, 1);
        check("in_ready_in_out", in_ready, 0);
        check("out_count", out_count, m_cnt);
        check("out_err", out_err, m_err);
        for (int k = 0; k < NP; k++) check($sformatf("out_llr[%0d]", k), $signed(out_llr[k*AW +: AW]), m_acc[k]);
        // A further read offered while the result waits must be refused.
        ms = mat_starts;
        in_strand = $urandom; in_len = LENW'(5); in_last = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("out_hold_valid", out_valid, 1);
        check("out_hold_count", out_count, m_cnt);
        check("in_ready_hold", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_drop", out_valid, 0);
        check("clr_count", out_count, 0);
        check("clr_err", out_err, 0);
        check("clr_llr", out_llr, 0);
        check("no_start_in_out", mat_starts, ms);
        model_clear();
    endtask

    task automatic do_read(input logic [DW-1:0] s, input int l, input bit last,
                           input int mlat, input int llat, input bit settle);
        bit out_now;
        int t;
        exp_strand = s; exp_len = LENW'(l);
        cur_mat_lat = mlat; cur_lik_lat = llat;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        check("in_ready_wait", in_ready, 1);
        in_strand = s; in_len = LENW'(l); in_last = last; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_read(l, last, mlat, llat, out_now);
        if (settle) begin
            t = 0;
            while (!(in_ready || out_valid) && t < 3 * TO + 30) begin @(negedge clk); t++; end
            if (out_now) check_out();
            else check("no_out_valid", out_valid, 0);
        end
    endtask

    task automatic set_lik(input int v);
        for (int k = 0; k < NP; k++) cur_lik[k] = v;
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 6);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ms, t, l, r;
        bit last;
        rst_n = 1'b0; in_valid = 1'b0; in_strand = '0; in_len = '0; in_last = 1'b0; out_ready = 1'b0;
        cur_mat_lat = 0; cur_lik_lat = 0; exp_strand = '0; exp_len = '0;
        set_lik(0);
        model_clear();
        #23;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_llr", out_llr, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_err", out_err, 0);
        check("rst_mat_start", eng_mat_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Single read, ascending likelihoods.
        for (int k = 0; k < NP; k++) cur_lik[k] = k + 1;
        do_read(32'hA5A5_0F0F, 16, 1'b1, 5, 7, 1'b1);

        // Four reads without last: OUT follows the fourth automatically.
        set_lik(-3);
        for (int i = 0; i < NS; i++) do_read($urandom, 12, 1'b0, 2, 3, 1'b1);

        // Saturation both ways.
        set_lik(100);
        do_read($urandom, 8, 1'b0, 1, 1, 1'b1);
        do_read($urandom, 8, 1'b1, 1, 1, 1'b1);
        set_lik(-100);
        do_read($urandom, 8, 1'b0, 1, 1, 1'b1);
        do_read($urandom, 8, 1'b1, 1, 1, 1'b1);

        // Length rejects start no engine.
        ms = mat_starts;
        do_read($urandom, 0, 1'b0, 3, 3, 1'b1);
        do_read($urandom, DW + 1, 1'b1, 3, 3, 1'b1);
        check("len_rej_no_start", mat_starts, ms);

        // Matrices timeout, then done on exactly the last allowed wait cycle.
        set_lik(9);
        do_read($urandom, 8, 1'b0, 0, 3, 1'b1);
        do_read($urandom, 8, 1'b1, TO, TO, 1'b1);

        // Reset during LIK_WAIT with a nonzero accumulator.
        set_lik(50);
        do_read($urandom, 10, 1'b0, 2, 2, 1'b1);
        do_read($urandom, 10, 1'b0, 2, 0, 1'b0);
        t = 0;
        while (!eng_lik_start && t < 50) begin @(negedge clk); t++; end
        check("saw_lik_start", eng_lik_start, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_llr", $signed(out_llr[AW-1:0]), 50);
        rst_n = 1'b0;
        #1;
        check("midrst_llr", out_llr, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_lik_start", eng_lik_start, 0);
        check("midrst_count", out_count, 0);
        check("midrst_strand", eng_strand, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        set_lik(7);
        do_read($urandom, 10, 1'b1, 3, 2, 1'b1);

        // Random read stream.
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            l = (r == 0) ? 0 : (r == 1) ? $urandom_range(DW + 1, (1 << LENW) - 1) : $urandom_range(1, DW);
            last = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NP; k++) cur_lik[k] = $urandom_range(0, 255) - 128;
            do_read($urandom, l, last, rand_lat(), rand_lat(), 1'b1);
        end
        if (m_rd > 0) begin
            set_lik(1);
            do_read($urandom, 4, 1'b1, 1, 1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
